// File: rtl/modem_pkg.sv
// Shared definitions for the modem I/Q link: deframer states, frame
// header/trailer constants and the frame length helper.
package modem_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;
  localparam logic       TRL_I  = 1'b1;
  localparam logic       TRL_Q  = 1'b0;

  // One frame carries an I half and a Q half, each 2 header + W data + 1 trailer bits.
  function automatic int frame_bits(input int w);
    return 2 * (w + 3);
  endfunction

endpackage

// File: rtl/iq_frame_check.sv
// Combinational frame inspector: flags a well-formed or all-zero frame
// window and splits out the I and Q sample fields.
module iq_frame_check
  import modem_pkg::*;
#(
  parameter  int W = 13,
  localparam int F = frame_bits(W)
) (
  input  logic [F-1:0] sr,
  output logic         good,
  output logic         idle,
  output logic [W-1:0] i,
  output logic [W-1:0] q
);

  localparam int H = F / 2;

  // I half occupies sr[F-1:H], Q half sr[H-1:0]; each is header, data, trailer.
  assign i    = sr[F-3 -: W];
  assign q    = sr[H-3 -: W];
  assign idle = (sr == '0);
  assign good = (sr[F-1 -: 2] == SYNC_I) && (sr[H] == TRL_I) &&
                (sr[H-1 -: 2] == SYNC_Q) && (sr[0] == TRL_Q);

endmodule

// File: rtl/iq_frame_rx.sv
// Receive deframer for the LVDS I/Q link: hunts for frame alignment,
// verifies and tracks it, and emits decimated signed I/Q sample pairs.
module iq_frame_rx
  import modem_pkg::*;
#(
  parameter int W           = 13,
  parameter int LANES       = 2,
  parameter int LOCK_FRAMES = 4,
  parameter int LOSS_FRAMES = 3,
  parameter int DECIM_W     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LANES-1:0]    rx_d,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                clr_err,
  output logic                out_valid,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic                locked,
  output logic                lost,
  output logic [15:0]         frame_err_cnt
);

  localparam int F    = frame_bits(W);
  localparam int NPH  = F / LANES;
  localparam int PH_W = $clog2(NPH);

  if (F % LANES != 0) begin : g_lane_check
    $error("iq_frame_rx: frame length must be a multiple of LANES");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rx_state_t           state, state_nxt;
  logic [F-1:0]        sr, sr_nxt;
  logic [LANES-1:0]    lane_bits;
  logic [PH_W-1:0]     ph;
  logic [3:0]          gcnt, gcnt_nxt;
  logic [3:0]          bcnt, bcnt_nxt;
  logic [DECIM_W-1:0]  dcnt, dcnt_nxt;
  logic                boundary, ph_clr, emit, err_inc, lost_nxt;
  logic                good, idle;
  logic [W-1:0]        fi, fq;
  logic                vld_p1, locked_p1, lost_p1;
  logic signed [W-1:0] i_p1, q_p1;
  logic [15:0]         err_cnt;

  // rx_d[0] arrived first, so it lands above the later lanes in the MSB-first window.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_bits[LANES-1-k] = rx_d[k];
  end

  // Frames are judged on the window as it will be after this edge, so the
  // registered outputs appear in the cycle right after the last bit enters.
  assign sr_nxt   = {sr[F-1-LANES:0], lane_bits};
  assign boundary = (ph == PH_W'(NPH - 1));

  iq_frame_check #(.W(W)) u_check (
    .sr   (sr_nxt),
    .good (good),
    .idle (idle),
    .i    (fi),
    .q    (fq)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    bcnt_nxt  = bcnt;
    dcnt_nxt  = dcnt;
    ph_clr    = 1'b0;
    emit      = 1'b0;
    err_inc   = 1'b0;
    lost_nxt  = 1'b0;
    unique case (state)
      HUNT: begin
        if (good) begin
          ph_clr   = 1'b1;
          gcnt_nxt = 4'd1;
          if (LOCK_FRAMES == 1) begin
            state_nxt = LOCKED;
            bcnt_nxt  = '0;
            dcnt_nxt  = '0;
          end else begin
            state_nxt = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (good) begin
            gcnt_nxt = gcnt + 4'd1;
            if (gcnt_nxt == 4'(LOCK_FRAMES)) begin
              state_nxt = LOCKED;
              bcnt_nxt  = '0;
              dcnt_nxt  = '0;
            end
          end else begin
            state_nxt = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (good) begin
            bcnt_nxt = '0;
            emit     = (dcnt == '0);
            dcnt_nxt = (dcnt >= decim) ? '0 : dcnt + 1'b1;
          end else if (idle) begin
            dcnt_nxt = '0;
          end else begin
            err_inc  = 1'b1;
            bcnt_nxt = bcnt + 4'd1;
            if (bcnt_nxt == 4'(LOSS_FRAMES)) begin
              state_nxt = HUNT;
              lost_nxt  = 1'b1;
              bcnt_nxt  = '0;
            end
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // p1: registered sample pair, status and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      ph        <= '0;
      gcnt      <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
      vld_p1    <= 1'b0;
      i_p1      <= '0;
      q_p1      <= '0;
      locked_p1 <= 1'b0;
      lost_p1   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      sr        <= sr_nxt;
      ph        <= (ph_clr || boundary) ? '0 : ph + 1'b1;
      gcnt      <= gcnt_nxt;
      bcnt      <= bcnt_nxt;
      dcnt      <= dcnt_nxt;
      vld_p1    <= emit;
      locked_p1 <= (state_nxt == LOCKED);
      lost_p1   <= lost_nxt;
      if (emit) begin
        i_p1 <= $signed(fi);
        q_p1 <= $signed(fq);
      end
      if (clr_err)      err_cnt <= '0;
      else if (err_inc) err_cnt <= sat_inc(err_cnt);
    end
  end

  assign out_valid     = vld_p1;
  assign out_i         = i_p1;
  assign out_q         = q_p1;
  assign locked        = locked_p1;
  assign lost          = lost_p1;
  assign frame_err_cnt = err_cnt;

endmodule

// File: tb/tb_iq_frame_rx.sv
// Directed bench for iq_frame_rx at default parameters (32-bit frame, 2 lanes).
module tb_iq_frame_rx;

  localparam int W = 13;
  localparam logic [31:0] GOOD = 32'h95797FFE;
  localparam logic [31:0] BADQ = 32'h95797FFF;
  localparam logic [31:0] IDLE = 32'h00000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr_err = 1'b0;
  logic [1:0] rx_d = 2'b00;
  logic [1:0] decim = 2'd0;
  logic out_valid, locked, lost;
  logic signed [W-1:0] out_i, out_q;
  logic [15:0] frame_err_cnt;

  int compared = 0;
  int mismatched = 0;
  int nvalid = 0;
  int nlost = 0;
  int vpos = -1;

  always #5 clk = ~clk;

  iq_frame_rx #(.W(13), .LANES(2), .LOCK_FRAMES(4), .LOSS_FRAMES(3), .DECIM_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_d          (rx_d),
    .decim         (decim),
    .clr_err       (clr_err),
    .out_valid     (out_valid),
    .out_i         (out_i),
    .out_q         (out_q),
    .locked        (locked),
    .lost          (lost),
    .frame_err_cnt (frame_err_cnt)
  );

  // Drive one lane pair (pair k of frame f) and observe the outputs just after the edge.
  task automatic drive_pair(input logic [31:0] f, input int k, input logic clr, input logic rst);
    @(negedge clk);
    rx_d[0] = f[31-2*k];
    rx_d[1] = f[30-2*k];
    clr_err = clr;
    reset   = rst;
    @(posedge clk);
    #1;
    if (out_valid) begin
      nvalid++;
      vpos = k;
    end
    if (lost) nlost++;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int k = 0; k < 16; k++) drive_pair(f, k, 1'b0, 1'b0);
  endtask

  task automatic send_frame_clr(input logic [31:0] f);
    for (int k = 0; k < 16; k++) drive_pair(f, k, (k == 15), 1'b0);
  endtask

  task automatic do_reset();
    drive_pair(IDLE, 0, 1'b0, 1'b1);
    drive_pair(IDLE, 0, 1'b0, 1'b1);
  endtask

  task automatic lock_up(input logic [1:0] d);
    decim = d;
    do_reset();
    repeat (4) send_frame(GOOD);
    nvalid = 0;
    nlost  = 0;
    vpos   = -1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
    compared++;
    if (locked !== 1'b0) begin mismatched++; $display("FAIL rst_locked: got %0b want 0", locked); end
    compared++;
    if (lost !== 1'b0) begin mismatched++; $display("FAIL rst_lost: got %0b want 0", lost); end
    compared++;
    if (out_i !== 13'h0000 || out_q !== 13'h0000) begin
      mismatched++; $display("FAIL rst_iq: got i=%0h q=%0h want 0 0", out_i, out_q);
    end
    compared++;
    if (frame_err_cnt !== 16'h0000) begin mismatched++; $display("FAIL rst_errcnt: got %0h want 0", frame_err_cnt); end
  endtask

  task automatic test_lock();
    int off;
    off = $urandom_range(1, 15);
    decim = 2'd0;
    do_reset();
    nvalid = 0;
    for (int k = off; k < 16; k++) drive_pair(GOOD, k, 1'b0, 1'b0);
    repeat (3) send_frame(GOOD);
    compared++;
    if (locked !== 1'b0) begin mismatched++; $display("FAIL lock_early: got %0b want 0 (offset %0d)", locked, off); end
    send_frame(GOOD);
    compared++;
    if (locked !== 1'b1) begin mismatched++; $display("FAIL lock_rise: got %0b want 1 (offset %0d)", locked, off); end
    compared++;
    if (nvalid !== 0) begin mismatched++; $display("FAIL lock_prevalid: got %0d strobes want 0", nvalid); end
    for (int n = 0; n < 3; n++) begin
      nvalid = 0;
      vpos   = -1;
      send_frame(GOOD);
      compared++;
      if (nvalid !== 1 || vpos !== 15) begin
        mismatched++; $display("FAIL lock_strobe%0d: got %0d strobes at pair %0d want 1 at 15", n, nvalid, vpos);
      end
      compared++;
      if (out_i !== 13'h0ABC || out_q !== 13'h1FFF) begin
        mismatched++; $display("FAIL lock_data%0d: got i=%0h q=%0h want 0abc 1fff", n, out_i, out_q);
      end
    end
    compared++;
    if (int'(out_q) !== -1) begin mismatched++; $display("FAIL lock_signed_q: got %0d want -1", int'(out_q)); end
  endtask

  task automatic test_decim();
    lock_up(2'd3);
    for (int n = 0; n < 8; n++) begin
      nvalid = 0;
      send_frame(GOOD);
      compared++;
      if (nvalid !== ((n % 4 == 0) ? 1 : 0)) begin
        mismatched++; $display("FAIL decim_frame%0d: got %0d strobes want %0d", n, nvalid, (n % 4 == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_errors();
    lock_up(2'd0);
    repeat (2) send_frame(BADQ);
    compared++;
    if (nvalid !== 0) begin mismatched++; $display("FAIL err_badvalid: got %0d strobes want 0", nvalid); end
    repeat (2) send_frame(GOOD);
    compared++;
    if (frame_err_cnt !== 16'd2) begin mismatched++; $display("FAIL err_count: got %0d want 2", frame_err_cnt); end
    compared++;
    if (locked !== 1'b1 || nlost !== 0) begin
      mismatched++; $display("FAIL err_locked: got locked=%0b lost_pulses=%0d want 1 0", locked, nlost);
    end
    compared++;
    if (nvalid !== 2) begin mismatched++; $display("FAIL err_resume: got %0d strobes want 2", nvalid); end
  endtask

  task automatic test_loss();
    lock_up(2'd0);
    repeat (2) send_frame(BADQ);
    compared++;
    if (locked !== 1'b1) begin mismatched++; $display("FAIL loss_early: got %0b want 1", locked); end
    send_frame(BADQ);
    compared++;
    if (nlost !== 1) begin mismatched++; $display("FAIL loss_pulse: got %0d pulses want 1", nlost); end
    compared++;
    if (locked !== 1'b0) begin mismatched++; $display("FAIL loss_locked: got %0b want 0", locked); end
    compared++;
    if (frame_err_cnt !== 16'd3) begin mismatched++; $display("FAIL loss_count: got %0d want 3", frame_err_cnt); end
    send_frame(GOOD);
    compared++;
    if (nlost !== 1 || locked !== 1'b0) begin
      mismatched++; $display("FAIL loss_after: got pulses=%0d locked=%0b want 1 0", nlost, locked);
    end
  endtask

  task automatic test_idle();
    lock_up(2'd0);
    repeat (5) send_frame(IDLE);
    compared++;
    if (nvalid !== 0) begin mismatched++; $display("FAIL idle_valid: got %0d strobes want 0", nvalid); end
    compared++;
    if (frame_err_cnt !== 16'd0) begin mismatched++; $display("FAIL idle_errcnt: got %0d want 0", frame_err_cnt); end
    compared++;
    if (locked !== 1'b1) begin mismatched++; $display("FAIL idle_locked: got %0b want 1", locked); end
    send_frame(GOOD);
    compared++;
    if (nvalid !== 1 || vpos !== 15 || out_i !== 13'h0ABC) begin
      mismatched++; $display("FAIL idle_resume: got %0d strobes pair %0d i=%0h want 1 15 0abc", nvalid, vpos, out_i);
    end
  endtask

  task automatic test_reset_mid();
    lock_up(2'd0);
    send_frame(GOOD);
    nvalid = 0;
    for (int k = 0; k < 7; k++) drive_pair(GOOD, k, 1'b0, 1'b0);
    drive_pair(GOOD, 7, 1'b0, 1'b1);
    compared++;
    if (out_valid !== 1'b0 || locked !== 1'b0 || lost !== 1'b0 || out_i !== 13'h0 || out_q !== 13'h0) begin
      mismatched++;
      $display("FAIL midrst_out: got v=%0b lk=%0b ls=%0b i=%0h q=%0h want all 0", out_valid, locked, lost, out_i, out_q);
    end
    for (int k = 8; k < 16; k++) drive_pair(GOOD, k, 1'b0, 1'b0);
    compared++;
    if (nvalid !== 0) begin mismatched++; $display("FAIL midrst_valid: got %0d strobes want 0", nvalid); end
    repeat (3) send_frame(GOOD);
    compared++;
    if (locked !== 1'b0) begin mismatched++; $display("FAIL midrst_early: got %0b want 0", locked); end
    send_frame(GOOD);
    compared++;
    if (locked !== 1'b1) begin mismatched++; $display("FAIL midrst_relock: got %0b want 1", locked); end
  endtask

  task automatic test_saturation();
    lock_up(2'd0);
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    send_frame(BADQ);
    compared++;
    if (frame_err_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_reach: got %0h want ffff", frame_err_cnt); end
    send_frame(BADQ);
    compared++;
    if (frame_err_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL sat_hold: got %0h want ffff", frame_err_cnt); end
    send_frame(GOOD);
  endtask

  task automatic test_clr();
    lock_up(2'd0);
    send_frame(BADQ);
    compared++;
    if (frame_err_cnt !== 16'd1) begin mismatched++; $display("FAIL clr_pre: got %0d want 1", frame_err_cnt); end
    send_frame(GOOD);
    send_frame_clr(BADQ);
    compared++;
    if (frame_err_cnt !== 16'd0) begin mismatched++; $display("FAIL clr_wins: got %0d want 0", frame_err_cnt); end
    send_frame(BADQ);
    compared++;
    if (frame_err_cnt !== 16'd1 || locked !== 1'b1) begin
      mismatched++; $display("FAIL clr_after: got cnt=%0d locked=%0b want 1 1", frame_err_cnt, locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_decim();
    test_errors();
    test_loss();
    test_idle();
    test_reset_mid();
    test_saturation();
    test_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
